// File: rtl/chocorrol_pkg.sv
// Shared definitions for the chocorrol multicycle control path.
// Holds the opcode constants, the control-field codes driven onto the
// datapath muxes, the sequencer state encoding and the packed control
// bundle passed from the state decoder to the sequencer top.
package chocorrol_pkg;

  localparam int OP_W    = 6;
  localparam int STATE_W = 4;

  // Opcodes, IR[31:26]
  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Sequencer states; encodings 14 and 15 are unused.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_HALT   = 4'd13
  } state_t;

  // Moore control bundle. IR write is absent: it only ever happens in
  // FETCH and is always qualified by memory-ready in the sequencer.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control decoder.
// Ports:
//   state      in   current sequencer state
//   ctrl       out  Moore control bundle for that state
//   fetchQual  out  high in FETCH; the sequencer gates PC/IR writes with it
module mc_ctrl_decode
  import chocorrol_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl,
  output logic   fetchQual
);

  always_comb begin
    ctrl      = '0;
    fetchQual = 1'b0;
    case (state)
      ST_FETCH: begin
        fetchQual    = 1'b1;
        ctrl.iorD    = 1'b0;
        ctrl.memRead = 1'b1;
        ctrl.aluSrcA = 1'b0;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.aluOp   = ALU_ADD;
        ctrl.pcSrc   = PCSRC_ALU;
      end
      ST_DECODE: begin
        // Speculative branch target: PC + (signext << 2)
        ctrl.aluSrcA = 1'b0;
        ctrl.aluSrcB = SRCB_IMMSH2;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_MEMRD: begin
        ctrl.iorD    = 1'b1;
        ctrl.memRead = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regDst   = 1'b0;
        ctrl.memToReg = 1'b1;
        ctrl.regWrite = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.iorD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      ST_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_REGB;
        ctrl.aluOp   = ALU_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.regDst   = 1'b1;
        ctrl.memToReg = 1'b0;
        ctrl.regWrite = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_REGB;
        ctrl.aluOp       = ALU_SUB;
        ctrl.pcSrc       = PCSRC_ALUOUT;
        ctrl.pcWriteCond = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pcSrc   = PCSRC_JUMP;
        ctrl.pcWrite = 1'b1;
      end
      ST_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALU_ADD;
      end
      ST_ADDIWB: begin
        ctrl.regDst   = 1'b0;
        ctrl.memToReg = 1'b0;
        ctrl.regWrite = 1'b1;
      end
      default: ;  // IDLE, HALT and unused encodings drive nothing
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle sequencer for the chocorrol MIPS datapath.
// Walks each instruction from FETCH to writeback, drives every datapath
// enable and mux select, stalls on memReadyIn, and traps unsupported
// opcodes into a HALT state that only reset leaves.
// Ports:
//   clkIn, rstnIn        clock, async active-low reset
//   opIn                 IR[31:26], looked at only in DECODE and MEMADR
//   memReadyIn           memory access completes this cycle
//   pc*/ior/mem*/ir*/reg*/alu*/pcSrc Out   datapath controls
//   stateOut             current state encoding (debug)
//   illegalOut           sticky unsupported-opcode flag
// Handshake: a memory access in FETCH, MEMRD or MEMWR keeps its strobe
// high every cycle until the cycle memReadyIn=1; that cycle completes it.
module mc_control_fsm
  import chocorrol_pkg::*;
(
  input  logic               clkIn,
  input  logic               rstnIn,
  input  logic [OP_W-1:0]    opIn,
  input  logic               memReadyIn,
  output logic               pcWriteOut,
  output logic               pcWriteCondOut,
  output logic               iorDOut,
  output logic               memReadOut,
  output logic               memWriteOut,
  output logic               irWriteOut,
  output logic               regDstOut,
  output logic               memToRegOut,
  output logic               regWriteOut,
  output logic               aluSrcAOut,
  output logic [1:0]         aluSrcBOut,
  output logic [1:0]         aluOpOut,
  output logic [1:0]         pcSrcOut,
  output logic [STATE_W-1:0] stateOut,
  output logic               illegalOut
);

  state_t state;
  state_t nextState;
  logic   illegal;
  ctrl_t  ctrl;
  logic   fetchQual;

  always_ff @(posedge clkIn or negedge rstnIn) begin
    if (!rstnIn) begin
      state   <= ST_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= nextState;
      if (nextState == ST_HALT) illegal <= 1'b1;
    end
  end

  always_comb begin
    nextState = ST_IDLE;
    case (state)
      ST_IDLE:   nextState = ST_FETCH;
      ST_FETCH:  nextState = memReadyIn ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opIn)
          OP_LW, OP_SW: nextState = ST_MEMADR;
          OP_R:         nextState = ST_EXEC;
          OP_BEQ:       nextState = ST_BRANCH;
          OP_J:         nextState = ST_JUMP;
          OP_ADDI:      nextState = ST_ADDIEX;
          default:      nextState = ST_HALT;
        endcase
      end
      ST_MEMADR: begin
        // opIn is re-read here; anything other than LW/SW is treated as
        // an unsupported opcode rather than guessing an access type.
        case (opIn)
          OP_LW:   nextState = ST_MEMRD;
          OP_SW:   nextState = ST_MEMWR;
          default: nextState = ST_HALT;
        endcase
      end
      ST_MEMRD:  nextState = memReadyIn ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  nextState = ST_FETCH;
      ST_MEMWR:  nextState = memReadyIn ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   nextState = ST_ALUWB;
      ST_ALUWB:  nextState = ST_FETCH;
      ST_BRANCH: nextState = ST_FETCH;
      ST_JUMP:   nextState = ST_FETCH;
      ST_ADDIEX: nextState = ST_ADDIWB;
      ST_ADDIWB: nextState = ST_FETCH;
      ST_HALT:   nextState = ST_HALT;
      default:   nextState = ST_IDLE;
    endcase
  end

  mc_ctrl_decode uDecode (
    .state     (state),
    .ctrl      (ctrl),
    .fetchQual (fetchQual)
  );

  // PC and IR only load in the FETCH cycle that actually returns data.
  assign pcWriteOut     = ctrl.pcWrite | (fetchQual & memReadyIn);
  assign irWriteOut     = fetchQual & memReadyIn;
  assign pcWriteCondOut = ctrl.pcWriteCond;
  assign iorDOut        = ctrl.iorD;
  assign memReadOut     = ctrl.memRead;
  assign memWriteOut    = ctrl.memWrite;
  assign regDstOut      = ctrl.regDst;
  assign memToRegOut    = ctrl.memToReg;
  assign regWriteOut    = ctrl.regWrite;
  assign aluSrcAOut     = ctrl.aluSrcA;
  assign aluSrcBOut     = ctrl.aluSrcB;
  assign aluOpOut       = ctrl.aluOp;
  assign pcSrcOut       = ctrl.pcSrc;
  assign stateOut       = state;
  assign illegalOut     = illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: a directed vector table for the reset,
// stall, branch/jump, halt and mid-instruction reset cases, then random
// instruction streams expanded into expected per-cycle control words.
module tb_mc_control_fsm;

  // ---------------- clock / reset / DUT ----------------
  logic       clk_in;
  logic       rstn_in;
  logic [5:0] op_in;
  logic       mem_ready_in;
  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mc_control_fsm dut (
    .clkIn          (clk_in),
    .rstnIn         (rstn_in),
    .opIn           (op_in),
    .memReadyIn     (mem_ready_in),
    .pcWriteOut     (pc_write),
    .pcWriteCondOut (pc_write_cond),
    .iorDOut        (ior_d),
    .memReadOut     (mem_read),
    .memWriteOut    (mem_write),
    .irWriteOut     (ir_write),
    .regDstOut      (reg_dst),
    .memToRegOut    (mem_to_reg),
    .regWriteOut    (reg_write),
    .aluSrcAOut     (alu_src_a),
    .aluSrcBOut     (alu_src_b),
    .aluOpOut       (alu_op),
    .pcSrcOut       (pc_src),
    .stateOut       (state_dbg),
    .illegalOut     (illegal)
  );

  // ---------------- expected control words ----------------
  // Packing: state, pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
  // regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegal
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  function automatic logic [20:0] cw(input logic [3:0] st,
      input logic pcw, input logic pcwc, input logic iord, input logic mrd,
      input logic mwr, input logic irw, input logic rdst, input logic m2r,
      input logic rwr, input logic sa, input logic [1:0] sb,
      input logic [1:0] aop, input logic [1:0] psrc, input logic ill);
    return {st, pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rwr, sa, sb, aop, psrc, ill};
  endfunction

  logic [20:0] w_idle, w_fetch_wait, w_fetch_go, w_decode, w_memadr, w_memrd;
  logic [20:0] w_memwb, w_memwr, w_exec, w_aluwb, w_branch, w_jump;
  logic [20:0] w_addiex, w_addiwb, w_halt;

  task automatic init_words();
    w_idle       = cw(4'd0,  0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    w_fetch_wait = cw(4'd1,  0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
    w_fetch_go   = cw(4'd1,  1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
    w_decode     = cw(4'd2,  0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
    w_memadr     = cw(4'd3,  0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    w_memrd      = cw(4'd4,  0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    w_memwb      = cw(4'd5,  0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0);
    w_memwr      = cw(4'd6,  0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
    w_exec       = cw(4'd7,  0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
    w_aluwb      = cw(4'd8,  0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0);
    w_branch     = cw(4'd9,  0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
    w_jump       = cw(4'd10, 1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0);
    w_addiex     = cw(4'd11, 0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
    w_addiwb     = cw(4'd12, 0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0);
    w_halt       = cw(4'd13, 0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 1);
  endtask

  logic [20:0] actual;
  assign actual = {state_dbg, pc_write, pc_write_cond, ior_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                   alu_op, pc_src, illegal};

  // ---------------- driver / checker ----------------
  int check_count = 0;
  int pass_count  = 0;

  task automatic step(input logic rstn, input logic [5:0] op, input logic rdy,
                      input logic [20:0] exp, input string tag);
    @(negedge clk_in);
    rstn_in      = rstn;
    op_in        = op;
    mem_ready_in = rdy;
    #1;
    check_count++;
    if (actual === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, actual, exp, $time);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rstn;
    logic [5:0]  op;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic rstn, input logic [5:0] op, input logic rdy,
                         input logic [20:0] exp);
    vec_t v;
    v.rstn = rstn; v.op = op; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic build_table();
    repeat (3) add_vec(0, R, 1, w_idle);     // reset held 3 cycles
    add_vec(1, R, 1, w_idle);                // released: IDLE one cycle
    // R-type: FETCH, DECODE, EXEC, ALUWB, FETCH on cycle 5
    add_vec(1, R, 1, w_fetch_go);
    add_vec(1, R, 1, w_decode);
    add_vec(1, R, 0, w_exec);
    add_vec(1, R, 0, w_aluwb);
    // LW with two not-ready cycles in MEMRD
    add_vec(1, LW, 1, w_fetch_go);
    add_vec(1, LW, 1, w_decode);
    add_vec(1, LW, 0, w_memadr);
    add_vec(1, LW, 0, w_memrd);
    add_vec(1, LW, 0, w_memrd);
    add_vec(1, LW, 1, w_memrd);
    add_vec(1, LW, 0, w_memwb);
    // SW with a stalled FETCH and one wait in MEMWR
    add_vec(1, SW, 0, w_fetch_wait);
    add_vec(1, SW, 1, w_fetch_go);
    add_vec(1, SW, 0, w_decode);
    add_vec(1, SW, 1, w_memadr);
    add_vec(1, SW, 0, w_memwr);
    add_vec(1, SW, 1, w_memwr);
    // BEQ then J
    add_vec(1, BEQ, 1, w_fetch_go);
    add_vec(1, BEQ, 1, w_decode);
    add_vec(1, BEQ, 1, w_branch);
    add_vec(1, J, 1, w_fetch_go);
    add_vec(1, J, 1, w_decode);
    add_vec(1, J, 1, w_jump);
    // ADDI
    add_vec(1, ADDI, 1, w_fetch_go);
    add_vec(1, ADDI, 1, w_decode);
    add_vec(1, ADDI, 1, w_addiex);
    add_vec(1, ADDI, 1, w_addiwb);
    // R-type interrupted by reset in EXEC: returns to IDLE asynchronously
    add_vec(1, R, 1, w_fetch_go);
    add_vec(1, R, 1, w_decode);
    add_vec(0, R, 1, w_idle);
    add_vec(1, R, 1, w_idle);
    // Unsupported opcode: HALT, sticky illegal for 10 cycles
    add_vec(1, BAD, 1, w_fetch_go);
    add_vec(1, BAD, 1, w_decode);
    for (int i = 0; i < 10; i++) add_vec(1, (i % 2 == 0) ? R : LW, i[0], w_halt);
    add_vec(0, R, 1, w_idle);                // only reset clears it
    add_vec(1, R, 1, w_idle);
  endtask

  // ---------------- reference model: instruction -> cycle words ----------------
  logic [20:0] exp_q[$];
  logic        rdy_q[$];
  logic [5:0]  op_q[$];

  task automatic push_cycle(input logic [20:0] w, input logic rdy, input logic [5:0] op);
    exp_q.push_back(w);
    rdy_q.push_back(rdy);
    op_q.push_back(op);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  // An instruction costs: fetch stalls + fetch + decode + class-specific
  // tail, with memory stalls only where a memory access is outstanding.
  task automatic plan_instr(input logic [5:0] op, input int fetch_wait, input int mem_wait);
    for (int i = 0; i < fetch_wait; i++) push_cycle(w_fetch_wait, 0, rnd_op());
    push_cycle(w_fetch_go, 1, rnd_op());
    push_cycle(w_decode, rnd_bit(), op);
    case (op)
      R:    begin push_cycle(w_exec, rnd_bit(), op); push_cycle(w_aluwb, rnd_bit(), op); end
      ADDI: begin push_cycle(w_addiex, rnd_bit(), op); push_cycle(w_addiwb, rnd_bit(), op); end
      BEQ:  push_cycle(w_branch, rnd_bit(), op);
      J:    push_cycle(w_jump, rnd_bit(), op);
      LW: begin
        push_cycle(w_memadr, rnd_bit(), op);
        for (int i = 0; i < mem_wait; i++) push_cycle(w_memrd, 0, op);
        push_cycle(w_memrd, 1, op);
        push_cycle(w_memwb, rnd_bit(), op);
      end
      SW: begin
        push_cycle(w_memadr, rnd_bit(), op);
        for (int i = 0; i < mem_wait; i++) push_cycle(w_memwr, 0, op);
        push_cycle(w_memwr, 1, op);
      end
      default: for (int i = 0; i < 5; i++) push_cycle(w_halt, rnd_bit(), rnd_op());
    endcase
  endtask

  logic [5:0] legal_ops[6];

  // ---------------- main ----------------
  initial begin
    rstn_in      = 1'b0;
    op_in        = '0;
    mem_ready_in = 1'b0;
    init_words();
    legal_ops[0] = R; legal_ops[1] = LW; legal_ops[2] = SW;
    legal_ops[3] = BEQ; legal_ops[4] = ADDI; legal_ops[5] = J;

    build_table();
    foreach (vecs[i])
      step(vecs[i].rstn, vecs[i].op, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));

    // Randomized streams, each started from a fresh reset and ended with a trap.
    for (int s = 0; s < 3; s++) begin
      step(0, R, 1, w_idle, "rand_reset");
      push_cycle(w_idle, rnd_bit(), rnd_op());
      for (int n = 0; n < 20; n++)
        plan_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3));
      plan_instr(BAD, $urandom_range(0, 2), 0);
      while (exp_q.size() > 0) begin
        logic [20:0] w;
        logic        r;
        logic [5:0]  o;
        w = exp_q.pop_front();
        r = rdy_q.pop_front();
        o = op_q.pop_front();
        step(1, o, r, w, $sformatf("rand%0d", s));
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
